// File: rtl/carry_bypass_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : carry_bypass_seq_adder_ctrl
// Description : Multi-cycle WIDTH-bit adder. One shared 4-bit carry-bypass
//               slice (ripple_carry_adder_bypass) processes one nibble per
//               clock, LSB first. The carry is chained through a register.
//               A start/ready/done handshake frames each add.
// Ports       : clk, rst (async, active-high)
//               start, a, b, cin          - request and operands (captured
//                                           when the request is accepted)
//               ready, busy, done         - IDLE / RUN / one-cycle DONE
//               sum, cout, overflow       - result of the last completed add
//               bypass_cnt                - nibbles whose slice bypassed
// Options     : BYPASS_STATS_EN - when defined, counts the bypassed nibbles
//               of each add. When undefined, bypass_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// ripple_carry_adder_bypass: 4-bit ripple adder with a carry-bypass path.
// When all four propagate bits are set, the carry-out is cin. The ripple
// chain does not need to settle in that case.
// ----------------------------------------------------------------------------
module ripple_carry_adder_bypass (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       bypass
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p    = a ^ b;
    assign w_g    = a & b;
    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign sum    = w_p ^ w_c[3:0];
    assign bypass = &w_p;
    assign cout   = bypass ? cin : w_c[4];
endmodule

// ----------------------------------------------------------------------------
// carry_bypass_seq_adder_ctrl: sequencing controller around the slice.
// ----------------------------------------------------------------------------
module carry_bypass_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              cin,
    output logic                              ready,
    output logic                              busy,
    output logic                              done,
    output logic [WIDTH-1:0]                  sum,
    output logic                              cout,
    output logic                              overflow,
    output logic [$clog2(WIDTH/4+1)-1:0]      bypass_cnt
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = $clog2(NSLICE);
    localparam int CNTW   = $clog2(NSLICE + 1);

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NSLICE - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_work_sum;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_slice_a;
    logic [3:0]       w_slice_b;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_bypass;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_final_sum;

    assign w_slice_a = r_op_a[4*r_idx +: 4];
    assign w_slice_b = r_op_b[4*r_idx +: 4];
    assign w_last    = (r_idx == c_last_idx);
    assign w_accept  = (r_state == c_st_idle) && start;

    ripple_carry_adder_bypass u_slice (
        .a      (w_slice_a),
        .b      (w_slice_b),
        .cin    (r_carry),
        .sum    (w_slice_sum),
        .cout   (w_slice_cout),
        .bypass (w_slice_bypass)
    );

    // The final nibble has not been written back yet on the RUN->DONE edge.
    // Merge it here so that sum and overflow see the complete result.
    always_comb begin
        w_final_sum                = r_work_sum;
        w_final_sum[4*r_idx +: 4]  = w_slice_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_work_sum <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_op_a     <= a;
                        r_op_b     <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_work_sum <= '0;
                        r_state    <= c_st_run;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_run: begin
                    r_work_sum[4*r_idx +: 4] <= w_slice_sum;
                    r_carry                  <= w_slice_cout;
                    r_idx                    <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= c_st_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_final_sum;
                        r_cout  <= w_slice_cout;
                        r_ovf   <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                                   (w_final_sum[WIDTH-1] != r_op_a[WIDTH-1]);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BYPASS_STATS_EN
    logic [CNTW-1:0] r_byp_cnt;
    logic [CNTW-1:0] r_byp_out;
    logic [CNTW-1:0] w_byp_next;

    assign w_byp_next = r_byp_cnt + {{(CNTW-1){1'b0}}, w_slice_bypass};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_cnt <= '0;
            r_byp_out <= '0;
        end else if (w_accept) begin
            r_byp_cnt <= '0;
        end else if (r_state == c_st_run) begin
            r_byp_cnt <= w_byp_next;
            if (w_last) begin
                r_byp_out <= w_byp_next;
            end
        end
    end

    assign bypass_cnt = r_byp_out;
`else
    // Statistics are compiled out. Keep the port driven, and give the
    // otherwise unobserved slice bypass flag a harmless sink.
    logic w_unused_stats;
    assign w_unused_stats = w_slice_bypass & w_accept;
    assign bypass_cnt     = (CNTW)'(w_unused_stats & 1'b0);
`endif

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_carry_bypass_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_bypass_seq_adder_ctrl
// Description : Self-checking bench for carry_bypass_seq_adder_ctrl. An
//               arithmetic reference model tracks the expected handshake and
//               the results. Directed adds pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_bypass_seq_adder_ctrl;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = $clog2(NSLICE + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             ready, busy, done, cout, overflow;
    logic [WIDTH-1:0] sum;
    logic [CW-1:0]    bypass_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    carry_bypass_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .cout       (cout),
        .overflow   (overflow),
        .bypass_cnt (bypass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 = waiting for a request, 1..NSLICE = nibble cycles,
    // NSLICE+1 = result cycle.
    int               m_phase = 0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_sum, p_sum;
    logic             m_cout, p_cout, m_ovf, p_ovf;
    int               m_byp, p_byp;

    function automatic int byp_count(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n;
        logic [WIDTH-1:0] t;
        n = 0;
`ifdef BYPASS_STATS_EN
        t = x ^ y;
        for (int i = 0; i < NSLICE; i++)
            if (t[4*i +: 4] == 4'hF) n++;
`else
        t = '0;
`endif
        return n + int'(t[0] & 1'b0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_byp   = 0;
            m_valid = 1'b1;
        end else if (m_phase == 0) begin
            if (start === 1'b1) begin
                {p_cout, p_sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                p_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (p_sum[WIDTH-1] != a[WIDTH-1]);
                p_byp   = byp_count(a, b);
                m_phase = 1;
            end
        end else if (m_phase < NSLICE) begin
            m_phase++;
        end else if (m_phase == NSLICE) begin
            m_sum   = p_sum;
            m_cout  = p_cout;
            m_ovf   = p_ovf;
            m_byp   = p_byp;
            m_phase = NSLICE + 1;
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid && !rst) begin
            chk("ready",      ready,      (m_phase == 0));
            chk("busy",       busy,       (m_phase >= 1 && m_phase <= NSLICE));
            chk("done",       done,       (m_phase == NSLICE + 1));
            chk("sum",        sum,        m_sum);
            chk("cout",       cout,       m_cout);
            chk("overflow",   overflow,   m_ovf);
            chk("bypass_cnt", bypass_cnt, m_byp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc, output int lat);
        start = 1'b1; a = ta; b = tb_; cin = tc;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic run_add(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic tc, input logic [WIDTH-1:0] es, input logic ec,
                           input logic eo, input int eb_on);
        int lat;
        int eb;
`ifdef BYPASS_STATS_EN
        eb = eb_on;
`else
        eb = 0 * eb_on;
`endif
        issue(ta, tb_, tc, lat);
        chk({name, "_latency"}, lat, NSLICE + 1);
        chk({name, "_sum"},  sum, es);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"},  overflow, eo);
        chk({name, "_byp"},  bypass_cnt, eb);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int pulses;
        // Asynchronous reset with no clock edge involved.
        #2 rst = 1'b1;
        #1;
        chk("rst_sum",   sum, 0);
        chk("rst_cout",  cout, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_done",  done, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_byp",   bypass_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_add("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_add("addFFFF", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4);
        run_add("add7FFF", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 2);

        // Continuous start with operands changing every cycle.
        pulses = 0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        start = 1'b0;
        chk("done_pulses_30cyc", pulses, 5);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of an add.
        start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sum",   sum, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_busy",  busy, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        run_add("add0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Randomized adds, including operands that force bypassed nibbles.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? (~ra ^ WIDTH'($urandom_range(0, 15) << (4 * $urandom_range(0, 3))))
                                             : WIDTH'($urandom);
            issue(ra, rb, 1'($urandom), lat);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
